// File: rtl/wallace_mac_pipe.sv
// ---------------------------------------------------------------------------
// wallace_mac_pipe : 2-stage handshaked Wallace-tree multiplier/accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wallace_mac_pipe #(
  parameter int W     = 12,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x_in,
  input  logic [W-1:0]       y_in,
  input  logic               is_signed,
  input  logic               acc_mode,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     result_out,
  output logic [ACC_W-1:0]   acc_out,
  output logic               acc_ovf
);

  localparam int PW   = 2 * W;
  localparam int NROW = W + 1;
  localparam int NGRP = NROW / 3;

  // Stage 1 registers
  logic [PW-1:0]    cs_sum_q, cs_sum_d;
  logic [PW-1:0]    cs_carry_q, cs_carry_d;
  logic             sgn_q, accm_q, clr_q, s1_valid_q;
  // Stage 2 registers
  logic [PW-1:0]    result_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             w_s1_load, w_s2_load;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_ext, w_sum;
  logic             w_add_ovf;

  assign w_s2_load = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | w_s2_load;
  assign w_s1_load = in_valid & in_ready;

  // Partial products (modified Baugh-Wooley when signed) reduced by levels of
  // parallel 3:2 compressors until two rows remain.
  always_comb begin
    logic [PW-1:0] rows [NROW];
    logic [PW-1:0] nxt  [NROW];
    int            n;
    int            m;
    for (int j = 0; j < W; j++) begin
      rows[j] = '0;
      for (int i = 0; i < W; i++) begin
        rows[j][i+j] = (x_in[i] & y_in[j]) ^ (is_signed & ((i == W-1) != (j == W-1)));
      end
    end
    rows[W]        = '0;
    rows[W][W]     = is_signed;
    rows[W][PW-1]  = is_signed;
    n = NROW;
    for (int lvl = 0; lvl < W; lvl++) begin
      for (int r = 0; r < NROW; r++) begin
        nxt[r] = '0;
      end
      m = 0;
      for (int g = 0; g < NGRP; g++) begin
        if (3*g + 2 < n) begin
          nxt[m]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
          nxt[m+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2])
                     | (rows[3*g+1] & rows[3*g+2])) << 1;
          m = m + 2;
        end
      end
      for (int r = 0; r < NROW; r++) begin
        if (r >= 3*(n/3) && r < n) begin
          nxt[m] = rows[r];
          m = m + 1;
        end
      end
      if (n > 2) begin
        for (int r = 0; r < NROW; r++) begin
          rows[r] = nxt[r];
        end
        n = m;
      end
    end
    cs_sum_d   = rows[0];
    cs_carry_d = rows[1];
  end

  assign w_prod    = cs_sum_q + cs_carry_q;
  assign w_ext     = {{(ACC_W-PW){sgn_q & w_prod[PW-1]}}, w_prod};
  assign w_sum     = acc_q + w_ext;
  assign w_add_ovf = (acc_q[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (w_s2_load) begin
      out_valid_d = 1'b1;
      if (accm_q) begin
        if (clr_q) begin
          acc_d = w_ext;
          ovf_d = 1'b0;
        end else begin
          acc_d = w_sum;
          ovf_d = ovf_q | w_add_ovf;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sum_q    <= '0;
      cs_carry_q  <= '0;
      sgn_q       <= 1'b0;
      accm_q      <= 1'b0;
      clr_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (w_s1_load) begin
        cs_sum_q   <= cs_sum_d;
        cs_carry_q <= cs_carry_d;
        sgn_q      <= is_signed;
        accm_q     <= acc_mode;
        clr_q      <= acc_clr;
      end
      // S1 empties when its entry moves on and nothing new replaces it.
      if (w_s1_load) begin
        s1_valid_q <= 1'b1;
      end else if (w_s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (w_s2_load) begin
        result_q <= w_prod;
      end
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result_out = result_q;
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wallace_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_mac_pipe : random + directed bench with a queue-based MAC model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_wallace_mac_pipe;
  localparam int W = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] x_in, y_in;
  logic        is_signed, acc_mode, acc_clr;
  logic        out_ready;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [23:0] result_a, result_b;
  logic [24:0] acc_a;
  logic [31:0] acc_b;
  logic        ovf_a, ovf_b;

  wallace_mac_pipe #(.W(W), .ACC_W(25)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .x_in(x_in), .y_in(y_in), .is_signed(is_signed), .acc_mode(acc_mode),
    .acc_clr(acc_clr), .out_valid(out_valid_a), .out_ready(out_ready),
    .result_out(result_a), .acc_out(acc_a), .acc_ovf(ovf_a));

  wallace_mac_pipe #(.W(W), .ACC_W(32)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .x_in(x_in), .y_in(y_in), .is_signed(is_signed), .acc_mode(acc_mode),
    .acc_clr(acc_clr), .out_valid(out_valid_b), .out_ready(out_ready),
    .result_out(result_b), .acc_out(acc_b), .acc_ovf(ovf_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] res;
    longint      a25;
    logic        o25;
    longint      a32;
    logic        o32;
    longint      edge_n;
    int          lm;
    logic [23:0] lr;
    logic [24:0] la25;
    logic        lo25;
    logic [31:0] la32;
    logic        lo32;
  } item_t;

  item_t  q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  longint edge_cnt = 0;
  longint m_acc25, m_acc32, sh_acc25, sh_acc32;
  logic   m_ovf25, m_ovf32, sh_ovf25, sh_ovf32;
  int     bp_mode = 0;
  int          lit_m = 0;
  logic [23:0] lit_r;
  logic [24:0] lit_a25;
  logic        lit_o25;
  logic [31:0] lit_a32;
  logic        lit_o32;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Accumulator semantics in plain integer arithmetic: true signed sum,
  // overflow when it leaves the ACC_W-bit signed range.
  function automatic void acc_step(input longint acc, input logic ovf, input longint pv,
                                   input logic am, input logic cl, input int aw,
                                   output longint nacc, output logic novf);
    longint md, half, s;
    md   = longint'(1) << aw;
    half = md / 2;
    nacc = acc;
    novf = ovf;
    if (am) begin
      if (cl) begin
        nacc = ((pv % md) + md) % md;
        novf = 1'b0;
      end else begin
        s    = ((acc >= half) ? acc - md : acc) + pv;
        novf = ovf | (s >= half) | (s < -half);
        nacc = ((s % md) + md) % md;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare process: every falling edge, check the DUTs against the model,
  // then advance the model by the transfers the coming rising edge performs.
  initial forever begin
    logic   exp_ir, exp_ov;
    longint pv;
    item_t  it;
    @(negedge clk);
    if (rst) begin
      q.delete();
      m_acc25 = 0; m_acc32 = 0; m_ovf25 = 0; m_ovf32 = 0;
      sh_acc25 = 0; sh_acc32 = 0; sh_ovf25 = 0; sh_ovf32 = 0;
    end else begin
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (q[0].edge_n <= edge_cnt - 1);
      chk("in_ready_a", in_ready_a, exp_ir);
      chk("in_ready_b", in_ready_b, exp_ir);
      chk("out_valid_a", out_valid_a, exp_ov);
      chk("out_valid_b", out_valid_b, exp_ov);
      if (exp_ov) begin
        chk("result_a", result_a, q[0].res);
        chk("result_b", result_b, q[0].res);
        chk("acc_a", acc_a, q[0].a25);
        chk("ovf_a", ovf_a, q[0].o25);
        chk("acc_b", acc_b, q[0].a32);
        chk("ovf_b", ovf_b, q[0].o32);
        if (q[0].lm[0]) chk("lit_result", result_a, q[0].lr);
        if (q[0].lm[1]) begin
          chk("lit_acc25", acc_a, q[0].la25);
          chk("lit_ovf25", ovf_a, q[0].lo25);
        end
        if (q[0].lm[2]) begin
          chk("lit_acc32", acc_b, q[0].la32);
          chk("lit_ovf32", ovf_b, q[0].lo32);
        end
      end else begin
        chk("acc_idle_a", acc_a, sh_acc25);
        chk("ovf_idle_a", ovf_a, sh_ovf25);
        chk("acc_idle_b", acc_b, sh_acc32);
        chk("ovf_idle_b", ovf_b, sh_ovf32);
      end
      if (exp_ov && out_ready) begin
        sh_acc25 = q[0].a25; sh_ovf25 = q[0].o25;
        sh_acc32 = q[0].a32; sh_ovf32 = q[0].o32;
        void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        pv = is_signed ? longint'($signed(x_in)) * longint'($signed(y_in))
                       : longint'(x_in) * longint'(y_in);
        it.res = pv[23:0];
        acc_step(m_acc25, m_ovf25, pv, acc_mode, acc_clr, 25, m_acc25, m_ovf25);
        acc_step(m_acc32, m_ovf32, pv, acc_mode, acc_clr, 32, m_acc32, m_ovf32);
        it.a25 = m_acc25; it.o25 = m_ovf25;
        it.a32 = m_acc32; it.o32 = m_ovf32;
        it.edge_n = edge_cnt + 1;
        it.lm = lit_m; it.lr = lit_r;
        it.la25 = lit_a25; it.lo25 = lit_o25;
        it.la32 = lit_a32; it.lo32 = lit_o32;
        q.push_back(it);
      end
    end
  end

  // Called only at rising edge + 1; returns at rising edge + 1 after acceptance.
  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic s,
                      input logic am, input logic cl, input int lm,
                      input logic [23:0] lr, input logic [24:0] la25, input logic lo25,
                      input logic [31:0] la32, input logic lo32);
    int k;
    x_in = x; y_in = y; is_signed = s; acc_mode = am; acc_clr = cl;
    lit_m = lm; lit_r = lr; lit_a25 = la25; lit_o25 = lo25; lit_a32 = la32; lit_o32 = lo32;
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready_a) break;
    end
    if (k == 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_m = 0;
  endtask

  task automatic drain();
    int k;
    bp_mode = 1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (k == 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid_a | out_valid_b, 0);
    chk({tag, "_result"}, {result_a, result_b}, 0);
    chk({tag, "_acc"}, {acc_a, acc_b}, 0);
    chk({tag, "_ovf"}, {ovf_a, ovf_b}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0;
    is_signed = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");
    chk("reset_in_ready", in_ready_a & in_ready_b, 1);
    bp_mode = 1;
    @(posedge clk); #1;

    // Unsigned corner
    send(12'hFFF, 12'hFFF, 0, 0, 0, 1, 24'hFFE001, '0, 0, '0, 0);
    repeat (3) @(posedge clk); #1;

    // Signed stream, back-to-back
    send(12'h800, 12'h800, 1, 0, 0, 1, 24'h400000, '0, 0, '0, 0);
    send(12'hFFF, 12'h001, 1, 0, 0, 1, 24'hFFFFFF, '0, 0, '0, 0);
    send(12'h7FF, 12'h800, 1, 0, 0, 1, 24'hC00800, '0, 0, '0, 0);
    drain();

    // Backpressure: two fill the pipe, third must wait
    bp_mode = 0;
    @(posedge clk); #1;
    send(12'h001, 12'h002, 0, 0, 0, 1, 24'h000002, '0, 0, '0, 0);
    send(12'h003, 12'h004, 0, 0, 0, 1, 24'h00000C, '0, 0, '0, 0);
    x_in = 12'h005; y_in = 12'h006; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready_a, 0);
    end
    @(posedge clk); #1;
    bp_mode = 1;
    send(12'h005, 12'h006, 0, 0, 0, 1, 24'h00001E, '0, 0, '0, 0);
    drain();

    // Signed accumulate into 25 bits, overflow then clear
    send(12'h800, 12'h800, 1, 1, 1, 2, '0, 25'h0400000, 0, '0, 0);
    send(12'h800, 12'h800, 1, 1, 0, 2, '0, 25'h0800000, 0, '0, 0);
    send(12'h800, 12'h800, 1, 1, 0, 2, '0, 25'h0C00000, 0, '0, 0);
    send(12'h800, 12'h800, 1, 1, 0, 2, '0, 25'h1000000, 1, '0, 0);
    send(12'h800, 12'h800, 1, 1, 1, 2, '0, 25'h0400000, 0, '0, 0);
    drain();

    // Unsigned accumulate with zero extension, then a non-accumulating op
    send(12'hFFF, 12'hFFF, 0, 1, 1, 4, '0, '0, 0, 32'h00FFE001, 0);
    send(12'hFFF, 12'hFFF, 0, 1, 0, 4, '0, '0, 0, 32'h01FFC002, 0);
    send(12'h003, 12'h005, 0, 0, 0, 5, 24'h00000F, '0, 0, 32'h01FFC002, 0);
    drain();

    // Asynchronous reset with both stages full
    bp_mode = 0;
    @(posedge clk); #1;
    send(12'h123, 12'h456, 0, 1, 0, 0, '0, '0, 0, '0, 0);
    send(12'h789, 12'h0AB, 1, 1, 0, 0, '0, '0, 0, '0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_reset_in_ready", in_ready_a, 1);
    bp_mode = 1;
    send(12'h002, 12'h003, 0, 1, 0, 7, 24'h000006, 25'h6, 0, 32'h6, 0);
    drain();

    // Randomised traffic with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send(12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 0, '0, '0, 0, '0, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
